// File: rtl/dataframe_reader.sv
// Drains the dataframe store and frames the returned words into header/data/trailer packets.
// Output stream: m_valid/m_data are held stable while m_valid && !m_ready; a word transfers on m_valid && m_ready.
module dataframe_reader #(
  parameter int DW         = 21,
  parameter int CW         = 7,
  parameter int MAX_BURST  = 28,
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [CW-1:0] buf_num_elem,
  output logic          buf_rd_en,
  input  logic [DW-1:0] buf_data_in,
  input  logic          buf_valid_in,
  output logic [DW+2:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          err_unexp,
  output logic [15:0]   pkt_cnt
);

  // The capture FIFO must hold every read that can be in flight plus the word on the output.
  localparam int SKID_EFF = (SKID_DEPTH < RD_LAT + 2) ? RD_LAT + 2 : SKID_DEPTH;
  localparam int AW       = $clog2(SKID_EFF);
  localparam int NW       = $clog2(SKID_EFF + 1);

  localparam logic [2:0]    TAG_HDR  = 3'b101;
  localparam logic [2:0]    TAG_DAT  = 3'b000;
  localparam logic [2:0]    TAG_TRL  = 3'b110;
  localparam logic [CW-1:0] MAX_B    = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(SKID_EFF - 1);
  localparam logic [AW-1:0] ONE_P    = AW'(1);
  localparam logic [NW-1:0] ONE_N    = NW'(1);
  localparam logic [NW:0]   DEPTH_W  = (NW + 1)'(SKID_EFF);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] burst_len_q, burst_len_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] sent_q, sent_d;
  logic [DW-1:0] csum_q, csum_d;
  logic [15:0]   pkt_cnt_q, pkt_cnt_d;
  logic          err_q, err_d;
  logic [NW-1:0] outst_q, outst_d;
  logic [NW-1:0] occ_q, occ_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [SKID_EFF];

  logic push, pop, hs;

  assign busy      = (state_q != IDLE);
  assign err_unexp = err_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign hs        = m_valid && m_ready;
  assign push      = buf_valid_in && (outst_q != '0);
  assign pop       = (state_q == DATA) && hs;

  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    case (state_q)
      HEADER: begin
        m_valid = 1'b1;
        m_data  = {TAG_HDR, {(DW-CW){1'b0}}, burst_len_q};
      end
      DATA: begin
        m_valid = (occ_q != '0);
        if (occ_q != '0) m_data = {TAG_DAT, mem_q[rd_ptr_q]};
      end
      TRAILER: begin
        m_valid = 1'b1;
        m_data  = {TAG_TRL, csum_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    burst_len_d = burst_len_q;
    issued_d    = issued_q;
    sent_d      = sent_q;
    csum_d      = csum_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_d       = err_q | (buf_valid_in && (outst_q == '0));
    buf_rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (buf_num_elem != '0) begin
          burst_len_d = (buf_num_elem > MAX_B) ? MAX_B : buf_num_elem;
          issued_d    = '0;
          sent_d      = '0;
          state_d     = HEADER;
        end
      end
      HEADER: begin
        if (m_ready) begin
          csum_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        // Reads in flight are counted against the FIFO so every return has a slot.
        buf_rd_en = (issued_q < burst_len_q) &&
                    (({1'b0, occ_q} + {1'b0, outst_q}) < DEPTH_W);
        if (buf_rd_en) issued_d = issued_q + ONE_C;
        if (hs) begin
          csum_d = csum_q ^ mem_q[rd_ptr_q];
          sent_d = sent_q + ONE_C;
          if (sent_q + ONE_C == burst_len_q) state_d = TRAILER;
        end
      end
      TRAILER: begin
        if (m_ready) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outst_d  = outst_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({buf_rd_en, push})
      2'b10:   outst_d = outst_q + ONE_N;
      2'b01:   outst_d = outst_q - ONE_N;
      default: ;
    endcase
    case ({push, pop})
      2'b10:   occ_d = occ_q + ONE_N;
      2'b01:   occ_d = occ_q - ONE_N;
      default: ;
    endcase
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + ONE_P;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + ONE_P;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= IDLE;
      burst_len_q <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      csum_q      <= '0;
      pkt_cnt_q   <= '0;
      err_q       <= 1'b0;
      outst_q     <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      burst_len_q <= burst_len_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      csum_q      <= csum_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_q       <= err_d;
      outst_q     <= outst_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= buf_data_in;
  end

endmodule

// File: tb/tb_dataframe_reader.sv
// Bench for dataframe_reader: behavioural store with adjustable read latency and a stream scoreboard.
module tb_dataframe_reader;
  localparam int DW = 21;
  localparam int CW = 7;
  localparam int W  = DW + 3;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic [CW-1:0] buf_num_elem = '0;
  logic          buf_rd_en;
  logic [DW-1:0] buf_data_in = '0;
  logic          buf_valid_in = 1'b0;
  logic [W-1:0]  m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          busy;
  logic          err_unexp;
  logic [15:0]   pkt_cnt;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] store_q[$];
  int            lat     = 1;
  logic          spur    = 1'b0;
  int            rd_cnt  = 0;
  int            hs_cnt  = 0;
  int            exp_pkt = 0;
  logic          pv [8];
  logic [DW-1:0] pd [8];

  always #5 clk = ~clk;

  dataframe_reader dut (
    .clk          (clk),
    .rstb         (rstb),
    .buf_num_elem (buf_num_elem),
    .buf_rd_en    (buf_rd_en),
    .buf_data_in  (buf_data_in),
    .buf_valid_in (buf_valid_in),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .busy         (busy),
    .err_unexp    (err_unexp),
    .pkt_cnt      (pkt_cnt)
  );

  initial begin
    for (int i = 0; i < 8; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
  end

  // Store model: a read strobe seen before an edge returns data lat cycles later.
  always begin : store_model
    logic fire;
    @(negedge clk);
    fire = buf_rd_en && rstb;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      pv[i] = pv[i+1];
      pd[i] = pd[i+1];
    end
    pv[7] = 1'b0;
    pd[7] = '0;
    if (fire) begin
      rd_cnt++;
      if (store_q.size() > 0) begin
        pv[lat-1] = 1'b1;
        pd[lat-1] = store_q.pop_front();
      end
    end
    buf_valid_in = pv[0] | spur;
    buf_data_in  = pv[0] ? pd[0] : '0;
    buf_num_elem = CW'(store_q.size());
  end

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!rstb) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", m_valid, m_data, prev_data);
        end
      end
      total++;
      if (int'(dut.occ_q) + int'(dut.outst_q) > 4) begin
        bad++;
        $display("FAIL skid_bound: occ+outstanding=%0d required <=4", int'(dut.occ_q) + int'(dut.outst_q));
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got=%h required none", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            bad++;
            $display("FAIL stream_word: got=%h required=%h", m_data, e);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  // Fill the store and push the packets the reader must produce from it.
  task automatic load_store(input int n, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] v[$];
    logic [DW-1:0] x;
    logic [DW-1:0] cs;
    int left;
    int k;
    int chunk;
    for (int i = 0; i < n; i++) begin
      x = rnd ? DW'($urandom_range(0, 2097151)) : base + DW'(i);
      v.push_back(x);
      store_q.push_back(x);
    end
    k = 0;
    left = n;
    while (left > 0) begin
      chunk = (left > 28) ? 28 : left;
      exp_q.push_back({3'b101, DW'(chunk)});
      cs = '0;
      for (int j = 0; j < chunk; j++) begin
        exp_q.push_back({3'b000, v[k]});
        cs ^= v[k];
        k++;
      end
      exp_q.push_back({3'b110, cs});
      exp_pkt++;
      left -= chunk;
    end
  endtask

  task automatic test_reset();
    #1;
    total += 6;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got=%b required=0", m_valid); end
    if (m_data !== '0) begin bad++; $display("FAIL rst_m_data: got=%h required=0", m_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got=%b required=0", busy); end
    if (buf_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got=%b required=0", buf_rd_en); end
    if (err_unexp !== 1'b0) begin bad++; $display("FAIL rst_err: got=%b required=0", err_unexp); end
    if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL rst_pkt_cnt: got=%0d required=0", pkt_cnt); end
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL empty_idle_busy: got=%b required=0", busy); end
    if (buf_rd_en !== 1'b0) begin bad++; $display("FAIL empty_idle_rd_en: got=%b required=0", buf_rd_en); end
  endtask

  task automatic test_single();
    int r0;
    r0 = rd_cnt;
    load_store(1, 21'h0000FF, 1'b0);
    for (int c = 0; c < 300 && !(exp_q.size() == 0 && !busy); c++) begin
      @(posedge clk); #1;
    end
    total += 4;
    if (exp_q.size() != 0 || busy) begin bad++; $display("FAIL single_timeout: left=%0d required=0", exp_q.size()); end
    if (rd_cnt - r0 != 1) begin bad++; $display("FAIL single_rd_pulses: got=%0d required=1", rd_cnt - r0); end
    if (pkt_cnt !== 16'(exp_pkt)) begin bad++; $display("FAIL single_pkt_cnt: got=%0d required=%0d", pkt_cnt, exp_pkt); end
    if (err_unexp !== 1'b0) begin bad++; $display("FAIL single_err: got=%b required=0", err_unexp); end
  endtask

  task automatic test_full();
    int r0;
    r0 = rd_cnt;
    load_store(28, '0, 1'b0);
    for (int c = 0; c < 500 && !(exp_q.size() == 0 && !busy); c++) begin
      @(posedge clk); #1;
    end
    total += 3;
    if (exp_q.size() != 0 || busy) begin bad++; $display("FAIL full_timeout: left=%0d required=0", exp_q.size()); end
    if (rd_cnt - r0 != 28) begin bad++; $display("FAIL full_rd_pulses: got=%0d required=28", rd_cnt - r0); end
    if (pkt_cnt !== 16'(exp_pkt)) begin bad++; $display("FAIL full_pkt_cnt: got=%0d required=%0d", pkt_cnt, exp_pkt); end
  endtask

  task automatic test_over_burst();
    int r0;
    r0 = rd_cnt;
    load_store(40, '0, 1'b1);
    for (int c = 0; c < 800 && !(exp_q.size() == 0 && !busy); c++) begin
      @(posedge clk); #1;
    end
    total += 3;
    if (exp_q.size() != 0 || busy) begin bad++; $display("FAIL over_timeout: left=%0d required=0", exp_q.size()); end
    if (rd_cnt - r0 != 40) begin bad++; $display("FAIL over_rd_pulses: got=%0d required=40", rd_cnt - r0); end
    if (pkt_cnt !== 16'(exp_pkt)) begin bad++; $display("FAIL over_pkt_cnt: got=%0d required=%0d", pkt_cnt, exp_pkt); end
  endtask

  task automatic test_backpressure();
    int r0;
    logic [3:0] pat;
    pat = 4'b1001;
    lat = 3;
    r0 = rd_cnt;
    load_store(28, '0, 1'b1);
    for (int c = 0; c < 1500 && !(exp_q.size() == 0 && !busy); c++) begin
      @(posedge clk); #1;
      m_ready = pat[c % 4];
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    lat = 1;
    total += 4;
    if (exp_q.size() != 0 || busy) begin bad++; $display("FAIL bp_timeout: left=%0d required=0", exp_q.size()); end
    if (rd_cnt - r0 != 28) begin bad++; $display("FAIL bp_rd_pulses: got=%0d required=28", rd_cnt - r0); end
    if (pkt_cnt !== 16'(exp_pkt)) begin bad++; $display("FAIL bp_pkt_cnt: got=%0d required=%0d", pkt_cnt, exp_pkt); end
    if (err_unexp !== 1'b0) begin bad++; $display("FAIL bp_err: got=%b required=0", err_unexp); end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    total++;
    if (err_unexp !== 1'b0) begin bad++; $display("FAIL spur_err_before: got=%b required=0", err_unexp); end
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    total += 3;
    if (err_unexp !== 1'b1) begin bad++; $display("FAIL spur_err_set: got=%b required=1", err_unexp); end
    if (m_valid !== 1'b0) begin bad++; $display("FAIL spur_m_valid: got=%b required=0", m_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL spur_busy: got=%b required=0", busy); end
    repeat (5) @(negedge clk);
    total++;
    if (err_unexp !== 1'b1) begin bad++; $display("FAIL spur_err_sticky: got=%b required=1", err_unexp); end
  endtask

  task automatic test_mid_reset();
    int r0;
    hs_cnt = 0;
    load_store(28, '0, 1'b1);
    for (int c = 0; c < 300 && hs_cnt < 6; c++) begin
      @(posedge clk);
    end
    total++;
    if (hs_cnt < 6) begin bad++; $display("FAIL mid_reach_timeout: handshakes=%0d required=6", hs_cnt); end
    #1 rstb = 1'b0;
    #1;
    total += 6;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid: got=%b required=0", m_valid); end
    if (m_data !== '0) begin bad++; $display("FAIL mid_m_data: got=%h required=0", m_data); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got=%b required=0", busy); end
    if (buf_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en: got=%b required=0", buf_rd_en); end
    if (err_unexp !== 1'b0) begin bad++; $display("FAIL mid_err: got=%b required=0", err_unexp); end
    if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL mid_pkt_cnt: got=%0d required=0", pkt_cnt); end
    exp_q.delete();
    store_q.delete();
    exp_pkt = 0;
    repeat (3) @(posedge clk);
    r0 = rd_cnt;
    load_store(3, '0, 1'b1);
    @(posedge clk);
    #1 rstb = 1'b1;
    for (int c = 0; c < 300 && !(exp_q.size() == 0 && !busy); c++) begin
      @(posedge clk); #1;
    end
    total += 4;
    if (exp_q.size() != 0 || busy) begin bad++; $display("FAIL mid_after_timeout: left=%0d required=0", exp_q.size()); end
    if (rd_cnt - r0 != 3) begin bad++; $display("FAIL mid_after_rd_pulses: got=%0d required=3", rd_cnt - r0); end
    if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL mid_after_pkt_cnt: got=%0d required=1", pkt_cnt); end
    if (err_unexp !== 1'b0) begin bad++; $display("FAIL mid_after_err: got=%b required=0", err_unexp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_over_burst();
    test_backpressure();
    test_spurious();
    test_mid_reset();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
